// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses pll_rst, waits for a debounced lock, then releases the domain resets in a staggered order.
// Optional lock-loss event counter is compiled in when PLL_SEQ_LOSS_CNT_EN is defined.
module pll_reset_sequencer #(
    parameter int  RST_PULSE_CYC    = 16,
    parameter int  LOCK_STABLE_CYC  = 1024,
    parameter int  LOCK_TIMEOUT_CYC = 65536,
    parameter int  N_DOMAINS        = 4,
    parameter int  STAGGER_CYC      = 8,
    parameter int  MAX_RETRIES      = 3,
    localparam int RETRY_W          = $clog2(MAX_RETRIES + 1)
) (
    input  logic                 refclk,
    input  logic                 rst,
    input  logic                 pll_locked,
    input  logic                 soft_req,
    output logic                 pll_rst,
    output logic [N_DOMAINS-1:0] dom_rst,
    output logic                 ready,
    output logic                 fail,
    output logic [RETRY_W-1:0]   retry_cnt,
    output logic [7:0]           loss_cnt
);

    localparam int REL_LAST = (N_DOMAINS - 1) * STAGGER_CYC;
    localparam int PH_MAX_A = (RST_PULSE_CYC > LOCK_STABLE_CYC) ? RST_PULSE_CYC : LOCK_STABLE_CYC;
    localparam int PH_MAX   = (PH_MAX_A > REL_LAST + 1) ? PH_MAX_A : REL_LAST + 1;
    localparam int PH_W     = $clog2(PH_MAX + 1);
    localparam int TMO_W    = $clog2(LOCK_TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_PULSE,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t               state, state_nxt;
    logic [PH_W-1:0]      ph_cnt, ph_cnt_nxt;
    logic [TMO_W-1:0]     tmo_cnt, tmo_cnt_nxt;
    logic [RETRY_W-1:0]   retry_nxt;
    logic                 lock_meta, lock_s;
    logic                 pll_rst_nxt, ready_nxt, fail_nxt;
    logic [N_DOMAINS-1:0] dom_rst_nxt;

    // pll_locked comes from the PLL's own timing domain, so it gets a two-flop synchronizer.
    // NOTE: clocked blocks use non-blocking (<=) so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state     <= S_PULSE;
            ph_cnt    <= '0;
            tmo_cnt   <= '0;
            retry_cnt <= '0;
        end else begin
            state     <= state_nxt;
            ph_cnt    <= ph_cnt_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            retry_cnt <= retry_nxt;
        end
    end

    // ph_cnt is the in-state cycle count for PULSE, STABLE and RELEASE; tmo_cnt spans one whole lock attempt.
    always_comb begin
        // NOTE: every variable gets a default first so no path through the block can infer a latch.
        state_nxt   = state;
        ph_cnt_nxt  = '0;
        tmo_cnt_nxt = tmo_cnt;
        retry_nxt   = retry_cnt;
        unique case (state)
            S_PULSE: begin
                tmo_cnt_nxt = '0;
                if (ph_cnt == PH_W'(RST_PULSE_CYC - 1)) state_nxt = S_WAIT_LOCK;
                else ph_cnt_nxt = ph_cnt + PH_W'(1);
            end
            S_WAIT_LOCK, S_STABLE: begin
                tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
                // Timeout outranks a debounce that completes in the same cycle.
                if (tmo_cnt == TMO_W'(LOCK_TIMEOUT_CYC - 1)) begin
                    if (retry_cnt < RETRY_W'(MAX_RETRIES)) begin
                        retry_nxt = retry_cnt + RETRY_W'(1);
                        state_nxt = S_PULSE;
                    end else begin
                        state_nxt = S_FAIL;
                    end
                end else if (!lock_s) begin
                    state_nxt = S_WAIT_LOCK;
                end else if (state == S_WAIT_LOCK) begin
                    state_nxt = S_STABLE;
                end else if (ph_cnt == PH_W'(LOCK_STABLE_CYC - 1)) begin
                    state_nxt = S_RELEASE;
                end else begin
                    ph_cnt_nxt = ph_cnt + PH_W'(1);
                end
            end
            S_RELEASE, S_RUN: begin
                if (!lock_s) begin
                    state_nxt = S_PULSE;
                    retry_nxt = '0;
                end else if (state == S_RELEASE) begin
                    if (ph_cnt == PH_W'(REL_LAST)) state_nxt = S_RUN;
                    else ph_cnt_nxt = ph_cnt + PH_W'(1);
                end
            end
            S_FAIL:  state_nxt = S_FAIL;
            default: state_nxt = S_PULSE;
        endcase
        if (soft_req) begin
            state_nxt  = S_PULSE;
            ph_cnt_nxt = '0;
            retry_nxt  = '0;
        end
    end

    // Outputs are decoded from the next state so the registered copies line up with the state they describe.
    always_comb begin
        pll_rst_nxt = (state_nxt == S_PULSE);
        ready_nxt   = (state_nxt == S_RUN);
        fail_nxt    = (state_nxt == S_FAIL);
        dom_rst_nxt = '1;
        if (state_nxt == S_RUN) begin
            dom_rst_nxt = '0;
        end else if (state_nxt == S_RELEASE) begin
            for (int i = 0; i < N_DOMAINS; i++)
                dom_rst_nxt[i] = (ph_cnt_nxt < PH_W'(i * STAGGER_CYC));
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            pll_rst <= 1'b1;
            dom_rst <= '1;
            ready   <= 1'b0;
            fail    <= 1'b0;
        end else begin
            pll_rst <= pll_rst_nxt;
            dom_rst <= dom_rst_nxt;
            ready   <= ready_nxt;
            fail    <= fail_nxt;
        end
    end

`ifdef PLL_SEQ_LOSS_CNT_EN
    logic lock_lost;

    // A software restart in the same cycle is not a lock-loss event.
    assign lock_lost = !soft_req && !lock_s && (state == S_RELEASE || state == S_RUN);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) loss_cnt <= 8'd0;
        else if (lock_lost && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
    end
`else
    assign loss_cnt = 8'd0;
`endif

endmodule
